// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the line-wide memory arbiter and its round-robin picker.
package mem_arb_pkg;

  localparam int unsigned MaxPorts = 8;
  localparam int unsigned MaxIdxW  = 3;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  function automatic logic [MaxPorts-1:0] onehot(input logic [MaxIdxW-1:0] idx,
                                                 input int unsigned        n);
    logic [MaxPorts-1:0] oh;
    oh = '0;
    for (int unsigned i = 0; i < MaxPorts; i++) begin
      if (i < n && idx == MaxIdxW'(i)) oh[i] = 1'b1;
    end
    return oh;
  endfunction

  // First requester at or after ptr, wrapping modulo n; ptr = 0 gives fixed priority.
  function automatic logic [MaxIdxW-1:0] rr_pick(input logic [MaxPorts-1:0] req,
                                                 input logic [MaxIdxW-1:0]  ptr,
                                                 input int unsigned         n);
    logic [MaxIdxW-1:0] win;
    logic               found;
    int unsigned        idx;
    win   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < MaxPorts; k++) begin
      idx = (32'(ptr) + k) % n;
      if (!found && k < n && req[idx[MaxIdxW-1:0]]) begin
        win   = idx[MaxIdxW-1:0];
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational winner select over N requesters with a registered round-robin pointer
// that moves past the winner whenever advance is strobed.
module rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned N     = 3,
  parameter bit          RR_EN = 1'b1,
  localparam int unsigned IdxW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  input  logic            advance,
  output logic [IdxW-1:0] winner,
  output logic            valid
);

  logic [IdxW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [MaxPorts-1:0] req_ext;

  always_comb begin
    req_ext        = '0;
    req_ext[N-1:0] = req;
    winner = IdxW'(rr_pick(req_ext, RR_EN ? MaxIdxW'(rr_ptr_q) : MaxIdxW'(0), N));
    valid  = |req;
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (RR_EN && advance) begin
      rr_ptr_d = (winner == IdxW'(N - 1)) ? '0 : winner + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_ptr_q <= '0;
    else        rr_ptr_q <= rr_ptr_d;
  end

endmodule

// File: rtl/mem_arbiter_rr.sv
// N-port cache-line arbiter onto one memory port: request captured at grant, registered
// one-cycle response followed by a guard cycle before the next arbitration.
module mem_arbiter_rr
  import mem_arb_pkg::*;
#(
  parameter int unsigned NUM_PORTS  = 3,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned LINE_WIDTH = 256,
  parameter bit          RR_EN      = 1'b1,
  localparam int unsigned IdW       = $clog2(NUM_PORTS)
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] ufp_addr,
  input  logic [NUM_PORTS-1:0]                 ufp_read,
  input  logic [NUM_PORTS-1:0]                 ufp_write,
  input  logic [NUM_PORTS-1:0][LINE_WIDTH-1:0] ufp_wdata,
  output logic [LINE_WIDTH-1:0]                ufp_rdata,
  output logic [NUM_PORTS-1:0]                 ufp_resp,
  output logic [ADDR_WIDTH-1:0]                dfp_addr,
  output logic                                 dfp_read,
  output logic                                 dfp_write,
  output logic [LINE_WIDTH-1:0]                dfp_wdata,
  input  logic [LINE_WIDTH-1:0]                dfp_rdata,
  input  logic                                 dfp_resp,
  output logic                                 busy,
  output logic [IdW-1:0]                       grant_id
);

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  dfp_addr_q, dfp_addr_d;
  logic [LINE_WIDTH-1:0]  dfp_wdata_q, dfp_wdata_d;
  logic                   dfp_read_q, dfp_read_d;
  logic                   dfp_write_q, dfp_write_d;
  logic [LINE_WIDTH-1:0]  ufp_rdata_q, ufp_rdata_d;
  logic [NUM_PORTS-1:0]   ufp_resp_q, ufp_resp_d;
  logic [IdW-1:0]         grant_id_q, grant_id_d;

  logic [NUM_PORTS-1:0]   req;
  logic [IdW-1:0]         win;
  logic                   any_req;
  logic                   advance;

  assign req     = ufp_read | ufp_write;
  assign advance = (state_q == IDLE) && any_req;

  rr_arbiter #(
    .N     (NUM_PORTS),
    .RR_EN (RR_EN)
  ) u_rr_arbiter (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .advance (advance),
    .winner  (win),
    .valid   (any_req)
  );

  always_comb begin
    state_d     = state_q;
    dfp_addr_d  = dfp_addr_q;
    dfp_wdata_d = dfp_wdata_q;
    dfp_read_d  = dfp_read_q;
    dfp_write_d = dfp_write_q;
    ufp_rdata_d = ufp_rdata_q;
    ufp_resp_d  = '0;
    grant_id_d  = grant_id_q;
    unique case (state_q)
      IDLE: begin
        dfp_read_d  = 1'b0;
        dfp_write_d = 1'b0;
        if (any_req) begin
          dfp_addr_d  = ufp_addr[win];
          dfp_wdata_d = ufp_wdata[win];
          dfp_read_d  = ufp_read[win];
          dfp_write_d = ufp_write[win];
          grant_id_d  = win;
          state_d     = BUSY;
        end
      end
      BUSY: begin
        if (dfp_resp) begin
          dfp_read_d  = 1'b0;
          dfp_write_d = 1'b0;
          ufp_rdata_d = dfp_rdata;
          ufp_resp_d  = NUM_PORTS'(onehot(MaxIdxW'(grant_id_q), NUM_PORTS));
          state_d     = RESP;
        end
      end
      // Guard cycle: the finished requester drops its request before the next pick.
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      dfp_addr_q  <= '0;
      dfp_wdata_q <= '0;
      dfp_read_q  <= 1'b0;
      dfp_write_q <= 1'b0;
      ufp_rdata_q <= '0;
      ufp_resp_q  <= '0;
      grant_id_q  <= '0;
    end else begin
      state_q     <= state_d;
      dfp_addr_q  <= dfp_addr_d;
      dfp_wdata_q <= dfp_wdata_d;
      dfp_read_q  <= dfp_read_d;
      dfp_write_q <= dfp_write_d;
      ufp_rdata_q <= ufp_rdata_d;
      ufp_resp_q  <= ufp_resp_d;
      grant_id_q  <= grant_id_d;
    end
  end

  assign dfp_addr  = dfp_addr_q;
  assign dfp_wdata = dfp_wdata_q;
  assign dfp_read  = dfp_read_q;
  assign dfp_write = dfp_write_q;
  assign ufp_rdata = ufp_rdata_q;
  assign ufp_resp  = ufp_resp_q;
  assign grant_id  = grant_id_q;
  assign busy      = (state_q != IDLE);

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_rw_excl
    a_rw_excl: assert property (@(posedge clk) disable iff (!rst_n)
                                !(ufp_read[i] && ufp_write[i]));
  end

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Bench for mem_arbiter_rr: round-robin DUT plus a fixed-priority twin on the same stimulus,
// a latency-programmable memory responder and a response scoreboard.
module tb_mem_arbiter_rr;

  localparam int NP = 3;
  localparam int AW = 32;
  localparam int LW = 256;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [NP-1:0][AW-1:0] ufp_addr;
  logic [NP-1:0]         ufp_read, ufp_write;
  logic [NP-1:0][LW-1:0] ufp_wdata;
  logic [LW-1:0]         dfp_rdata;
  logic                  dfp_resp;

  logic [LW-1:0] ufp_rdata, dfp_wdata, fp_ufp_rdata, fp_dfp_wdata;
  logic [NP-1:0] ufp_resp, fp_ufp_resp;
  logic [AW-1:0] dfp_addr, fp_dfp_addr;
  logic          dfp_read, dfp_write, busy, fp_dfp_read, fp_dfp_write, fp_busy;
  logic [1:0]    grant_id, fp_grant_id;

  mem_arbiter_rr #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .LINE_WIDTH(LW), .RR_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .ufp_addr(ufp_addr), .ufp_read(ufp_read),
    .ufp_write(ufp_write), .ufp_wdata(ufp_wdata), .ufp_rdata(ufp_rdata),
    .ufp_resp(ufp_resp), .dfp_addr(dfp_addr), .dfp_read(dfp_read), .dfp_write(dfp_write),
    .dfp_wdata(dfp_wdata), .dfp_rdata(dfp_rdata), .dfp_resp(dfp_resp), .busy(busy),
    .grant_id(grant_id)
  );

  mem_arbiter_rr #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .LINE_WIDTH(LW), .RR_EN(1'b0)) dut_fp (
    .clk(clk), .rst_n(rst_n), .ufp_addr(ufp_addr), .ufp_read(ufp_read),
    .ufp_write(ufp_write), .ufp_wdata(ufp_wdata), .ufp_rdata(fp_ufp_rdata),
    .ufp_resp(fp_ufp_resp), .dfp_addr(fp_dfp_addr), .dfp_read(fp_dfp_read),
    .dfp_write(fp_dfp_write), .dfp_wdata(fp_dfp_wdata), .dfp_rdata(dfp_rdata),
    .dfp_resp(dfp_resp), .busy(fp_busy), .grant_id(fp_grant_id)
  );

  typedef struct {
    logic [NP-1:0] resp;
    logic [1:0]    port;
    logic          rd;
    logic          wr;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
    logic [LW-1:0] rdata;
  } exp_t;

  typedef struct {
    logic [1:0]    port;
    logic          rd;
    logic          wr;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
    int            lat;
    logic [LW-1:0] rdata;
    logic [NP-1:0] exp_resp;
    int            exp_hi;
  } vec_t;

  exp_t exp_q[$];
  int   resp_cyc[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   resp_cnt = 0;
  int   cyc = 0;
  int   txn_cnt = 0;
  int   act_cnt = 0;
  int   mem_cnt = 0;
  int   mem_lat = 1;
  logic mem_auto = 1'b0;
  logic prev_act = 1'b0;
  logic [LW-1:0] mem_rdata = '0;

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic fail_evt(input string name, input string act, input string exp);
    n_checks++;
    n_errors++;
    $display("FAIL %s: got %s, required %s", name, act, exp);
  endtask

  task automatic push(input logic [1:0] port, input logic rd, input logic wr,
                      input logic [AW-1:0] addr, input logic [LW-1:0] wdata,
                      input logic [LW-1:0] rdata, input logic [NP-1:0] resp);
    exp_t e;
    e.resp = resp; e.port = port; e.rd = rd; e.wr = wr;
    e.addr = addr; e.wdata = wdata; e.rdata = rdata;
    exp_q.push_back(e);
  endtask

  task automatic wait_resp(input int target, input int budget, input string name);
    int i = 0;
    while (resp_cnt < target && i < budget) begin
      @(negedge clk); #1;
      i++;
    end
    if (resp_cnt < target) fail_evt(name, "no ufp_resp within budget", "ufp_resp pulse");
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    ufp_read = '0;
    ufp_write = '0;
    dfp_resp = 1'b0;
    mem_cnt = 0;
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: responds mem_lat cycles after a request appears on dfp.
  always @(negedge clk) begin
    if ((dfp_read || dfp_write) && !prev_act) txn_cnt++;
    prev_act = dfp_read || dfp_write;
    if (dfp_read || dfp_write) act_cnt++;
    if (mem_auto && dfp_resp) begin
      dfp_resp = 1'b0;
    end else if (mem_auto && (dfp_read || dfp_write)) begin
      mem_cnt++;
      if (mem_cnt >= mem_lat) begin
        mem_cnt = 0;
        if (exp_q.size() == 0) begin
          fail_evt("dfp_unexpected_txn", "dfp request", "no request");
        end else begin
          check("dfp_addr", dfp_addr, exp_q[0].addr);
          check("dfp_read", dfp_read, exp_q[0].rd);
          check("dfp_write", dfp_write, exp_q[0].wr);
          if (exp_q[0].wr) check("dfp_wdata", dfp_wdata, exp_q[0].wdata);
        end
        dfp_rdata = mem_rdata;
        dfp_resp = 1'b1;
      end
    end else begin
      mem_cnt = 0;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (ufp_resp != '0) begin
      resp_cnt++;
      resp_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        check("ufp_resp_unexpected", ufp_resp, '0);
      end else begin
        e = exp_q.pop_front();
        check("ufp_resp", ufp_resp, e.resp);
        check("grant_id", grant_id, e.port);
        if (e.rd) check("ufp_rdata", ufp_rdata, e.rdata);
      end
    end
  end

  vec_t vecs[5];
  logic [1:0] rr_order[6];

  initial begin
    int base, s, t0;
    ufp_addr = '0; ufp_wdata = '0; ufp_read = '0; ufp_write = '0;
    dfp_rdata = '0; dfp_resp = 1'b0; rst_n = 1'b0;

    vecs[0] = '{2'd1, 1'b1, 1'b0, 32'h0000_1040, 256'h0, 4, {32{8'hA5}}, 3'b010, 4};
    vecs[1] = '{2'd0, 1'b1, 1'b0, 32'h0000_2000, 256'h0, 2, {8{32'h5A5A_0F0F}}, 3'b001, 2};
    vecs[2] = '{2'd2, 1'b0, 1'b1, 32'h0000_3000, {8{32'h1234_5678}}, 3, 256'h0, 3'b100, 3};
    vecs[3] = '{2'd1, 1'b0, 1'b1, 32'hFFFF_FFC0, {8{32'hFFFF_FFFF}}, 1, 256'h0, 3'b010, 1};
    vecs[4] = '{2'd2, 1'b1, 1'b0, 32'h0000_0040, 256'h0, 6, {8{32'hDEAD_BEEF}}, 3'b100, 6};
    rr_order = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};

    repeat (2) @(negedge clk);
    check("rst_dfp_read", dfp_read, 0);
    check("rst_dfp_write", dfp_write, 0);
    check("rst_ufp_resp", ufp_resp, 0);
    check("rst_busy", busy, 0);
    check("rst_dfp_addr", dfp_addr, 0);
    check("rst_dfp_wdata", dfp_wdata, 0);
    check("rst_ufp_rdata", ufp_rdata, 0);
    check("rst_grant_id", grant_id, 0);
    rst_n = 1'b1;
    @(negedge clk);
    mem_auto = 1'b1;

    // Single transactions from the vector table.
    foreach (vecs[v]) begin
      act_cnt = 0;
      mem_lat = vecs[v].lat;
      mem_rdata = vecs[v].rdata;
      push(vecs[v].port, vecs[v].rd, vecs[v].wr, vecs[v].addr, vecs[v].wdata,
           vecs[v].rdata, vecs[v].exp_resp);
      ufp_addr[vecs[v].port] = vecs[v].addr;
      ufp_wdata[vecs[v].port] = vecs[v].wdata;
      ufp_read[vecs[v].port] = vecs[v].rd;
      ufp_write[vecs[v].port] = vecs[v].wr;
      wait_resp(resp_cnt + 1, 40, "vec_timeout");
      ufp_read = '0;
      ufp_write = '0;
      repeat (2) @(negedge clk);
      check("vec_dfp_active_cycles", act_cnt, vecs[v].exp_hi);
      check("vec_busy_after", busy, 0);
    end

    // All three ports requesting continuously.
    reset_dut();
    mem_lat = 2;
    mem_rdata = {8{32'hC0DE_0000}};
    for (int p = 0; p < NP; p++) ufp_addr[p] = 32'h100 * (p + 1);
    foreach (rr_order[k])
      push(rr_order[k], 1'b1, 1'b0, 32'h100 * (rr_order[k] + 1), 256'h0, mem_rdata,
           3'b001 << rr_order[k]);
    base = resp_cnt;
    ufp_read = 3'b111;
    for (int k = 1; k <= 6; k++) begin
      wait_resp(base + k, 30, "rr_timeout");
      check("fp_grant_id", fp_grant_id, 0);
      if (k == 6) ufp_read = '0;
    end
    repeat (3) @(negedge clk);
    check("rr_idle_after", busy, 0);

    // Requester holds read through its response cycle, then drops it.
    reset_dut();
    mem_lat = 1;
    push(2'd0, 1'b1, 1'b0, 32'h100, 256'h0, mem_rdata, 3'b001);
    push(2'd1, 1'b1, 1'b0, 32'h200, 256'h0, mem_rdata, 3'b010);
    base = resp_cnt;
    t0 = txn_cnt;
    ufp_read = 3'b011;
    wait_resp(base + 1, 20, "guard_timeout");
    ufp_read[0] = 1'b0;
    wait_resp(base + 2, 20, "guard_timeout");
    check("guard_fp_grant_id", fp_grant_id, 1);
    ufp_read[1] = 1'b0;
    repeat (4) @(negedge clk);
    check("guard_txn_count", txn_cnt - t0, 2);

    // Write request whose address and data change while the transaction is in flight.
    mem_lat = 5;
    push(2'd2, 1'b0, 1'b1, 32'h0000_5000, {8{32'h1234_5678}}, mem_rdata, 3'b100);
    base = resp_cnt;
    ufp_addr[2] = 32'h0000_5000;
    ufp_wdata[2] = {8{32'h1234_5678}};
    ufp_write[2] = 1'b1;
    @(negedge clk); @(negedge clk);
    ufp_addr[2] = 32'hDEAD_0000;
    ufp_wdata[2] = {8{32'h0BAD_F00D}};
    @(negedge clk);
    check("hold_dfp_addr", dfp_addr, 32'h0000_5000);
    check("hold_dfp_wdata", dfp_wdata, {8{32'h1234_5678}});
    wait_resp(base + 1, 20, "hold_timeout");
    ufp_write = '0;
    repeat (2) @(negedge clk);

    // Reset in the middle of a transaction, then a stray memory response.
    mem_auto = 1'b0;
    ufp_addr[1] = 32'h0000_7000;
    ufp_read[1] = 1'b1;
    s = 0;
    while (!dfp_read && s < 10) begin @(negedge clk); s++; end
    if (!dfp_read) fail_evt("rst_mid_start", "no dfp_read", "dfp_read high");
    @(negedge clk);
    rst_n = 1'b0;
    ufp_read = '0;
    #1;
    check("rst_mid_dfp_read_async", dfp_read, 0);
    check("rst_mid_busy_async", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    dfp_rdata = {8{32'hBAD0_BAD0}};
    dfp_resp = 1'b1;
    @(negedge clk);
    dfp_resp = 1'b0;
    @(negedge clk);
    check("late_resp_ufp_resp", ufp_resp, 0);
    check("late_resp_busy", busy, 0);
    check("late_resp_ufp_rdata", ufp_rdata, 0);
    check("late_resp_dfp_read", dfp_read, 0);
    mem_auto = 1'b1;

    // Back-to-back requests from port 0 with one-cycle memory.
    reset_dut();
    mem_lat = 1;
    mem_rdata = {8{32'h0000_F00D}};
    for (int k = 0; k < 4; k++) push(2'd0, 1'b1, 1'b0, 32'h40, 256'h0, mem_rdata, 3'b001);
    base = resp_cnt;
    s = resp_cyc.size();
    t0 = txn_cnt;
    ufp_addr[0] = 32'h40;
    ufp_read[0] = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      wait_resp(base + k, 10, "b2b_timeout");
      if (k == 4) ufp_read = '0;
    end
    repeat (3) @(negedge clk);
    check("b2b_txn_count", txn_cnt - t0, 4);
    if (resp_cyc.size() >= s + 4) begin
      for (int k = 1; k < 4; k++)
        check("b2b_period", resp_cyc[s + k] - resp_cyc[s + k - 1], 3);
    end else begin
      fail_evt("b2b_resp_count", "fewer than 4 responses", "4 responses");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_arbiter_rr.md
Name: mem_arbiter_rr

Overview:
- Parametrised N-port arbiter that multiplexes cache-line requesters onto the single line-wide memory port (dfp). Typical requesters are icache, dcache and prefetcher.
- Successor to the two-port fixed-priority arbiter, with these additions:
  - NUM_PORTS requesters.
  - Selectable fixed-priority or round-robin arbitration.
  - Request capture at grant, so dfp outputs are registered and stable for the whole transaction.
  - Registered response with a guard cycle, so a completed requester cannot be re-granted on its stale request.

Parameters:
- NUM_PORTS, 3, number of upstream requesters (2..8); port 0 has highest fixed priority.
- ADDR_WIDTH, 32, request address width.
- LINE_WIDTH, 256, cache-line data width.
- RR_EN, 1, 0 = fixed priority (lowest index wins); 1 = round-robin.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ufp_addr  in  NUM_PORTS x ADDR_WIDTH  per-port request address.
- ufp_read  in  NUM_PORTS  per-port read request, held until that port's ufp_resp.
- ufp_write  in  NUM_PORTS  per-port write request, held until that port's ufp_resp.
- ufp_wdata  in  NUM_PORTS x LINE_WIDTH  per-port write line.
- ufp_rdata  out  LINE_WIDTH  read line, shared by all ports, valid only with a ufp_resp bit.
- ufp_resp  out  NUM_PORTS  one-hot, one-cycle completion pulse.
- dfp_addr  out  ADDR_WIDTH  memory request address (registered).
- dfp_read  out  1  memory read (registered).
- dfp_write  out  1  memory write (registered).
- dfp_wdata  out  LINE_WIDTH  memory write line (registered).
- dfp_rdata  in  LINE_WIDTH  memory read line, valid with dfp_resp.
- dfp_resp  in  1  memory completion pulse.
- busy  out  1  high in BUSY and RESP states.
- grant_id  out  $clog2(NUM_PORTS)  index of the current or last granted port.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE.
  - dfp_read, dfp_write, ufp_resp, busy = 0.
  - dfp_addr, dfp_wdata, ufp_rdata, grant_id = 0.
  - rr_ptr = 0.
  - Reset mid-transaction aborts it silently; a dfp_resp arriving after reset release while in IDLE is ignored.
- Request definition: req[i] = ufp_read[i] | ufp_write[i]. Read and write asserted together on one port is illegal; this is covered by an assertion, and the RTL forwards both bits unchanged.
- IDLE state:
  - If any req, pick winner W.
    - RR_EN = 0: lowest set index.
    - RR_EN = 1: first set index at or after rr_ptr, wrapping modulo NUM_PORTS.
  - On the next edge: latch ufp_addr[W], ufp_wdata[W], ufp_read[W], ufp_write[W] into dfp_* registers; set grant_id = W; if RR_EN, set rr_ptr = (W+1) mod NUM_PORTS; go to BUSY.
  - If no req, stay in IDLE with dfp_read = dfp_write = 0.
- BUSY state:
  - dfp_* hold the latched values; upstream changes are ignored.
  - On dfp_resp: clear dfp_read and dfp_write, register ufp_rdata <= dfp_rdata, set ufp_resp <= one-hot(grant_id), go to RESP.
- RESP state:
  - ufp_resp is high for exactly this one cycle; no arbitration occurs.
  - Next edge: ufp_resp = 0, go to IDLE. This guard cycle lets the requester drop its request.
- Latency:
  - Request visible at edge 0 gives dfp_read/write high after edge 1.
  - dfp_resp sampled at edge k gives ufp_resp high in the cycle after edge k.
  - Minimum turnaround is 3 cycles per transaction.
- dfp_resp in IDLE or RESP is ignored, with no output effect.
- Simultaneous requests: only one is granted per transaction; losers remain pending and are unaffected.
- Fairness: with RR_EN = 1, a continuously requesting port is served within NUM_PORTS transactions.
- ufp_rdata keeps its last value between responses. On a write response it is loaded with dfp_rdata, which is don't-care.

Decomposition:
- Package mem_arb_pkg holds:
  - the state enum {IDLE, BUSY, RESP};
  - the function onehot(idx, n);
  - the function rr_pick(req, ptr) (rotate, priority-encode, un-rotate).
- Sub-module rr_arbiter (parameter N, RR_EN): combinational winner select plus registered rr_ptr with an advance strobe. Reusable for other shared ports.

Test Plan:
- Single read on port 1, addr 0x0000_1040; memory responds after 4 cycles with 0xA5..A5 -> dfp_read high for exactly 4 cycles with dfp_addr 0x1040; ufp_resp = 3'b010 for 1 cycle; ufp_rdata = 0xA5..A5.
- RR_EN = 1, ports 0, 1, 2 all requesting continuously -> grant_id sequence 0, 1, 2, 0, 1, 2; fixed-priority build (RR_EN = 0) -> 0, 0, 0...
- Port 2 writes 0x1234..; port 2 changes ufp_addr/ufp_wdata mid-BUSY -> dfp_addr and dfp_wdata keep the captured values until dfp_resp.
- Requester keeps ufp_read high during its RESP cycle, then drops it -> no second dfp transaction, and the next grant goes to another pending port.
- Assert rst_n low for 1 cycle while BUSY -> dfp_read drops asynchronously; after release, a late dfp_resp produces no ufp_resp and state remains IDLE.
- Port 0 requests back-to-back with dfp_resp always 1 cycle -> transactions complete every 3 cycles, each with exactly one ufp_resp pulse.
